// File: rtl/onchip_ram_burst_adapter.sv
// Avalon-MM burst slave that feeds a single-port on-chip RAM one word per cycle.
// Optional `ONCHIP_RAM_RANGE_CHECK_EN adds s_response/err_sticky and out-of-range beat suppression.
module onchip_ram_burst_adapter #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 5120,
    parameter int BURST_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     s_address,
    input  logic [BURST_W-1:0]    s_burstcount,
    input  logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_read,
    input  logic                  s_write,
    input  logic [DATA_W-1:0]     s_writedata,
    output logic                  s_waitrequest,
    output logic [DATA_W-1:0]     s_readdata,
    output logic                  s_readdatavalid,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
`ifdef ONCHIP_RAM_RANGE_CHECK_EN
    output logic [1:0]            s_response,
    output logic                  err_sticky,
`endif
    input  logic [DATA_W-1:0]     ram_readdata
);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t               state_reg, state_next;
    logic [ADDR_W-1:0]    addr_reg, addr_next;
    logic [BURST_W-1:0]   cnt_reg, cnt_next;
    logic                 rd_pending_reg, rd_pending_next;
    logic [BURST_W-1:0]   beats;
    logic                 cs_raw, wr_raw, beat_ok;

    // The top word wraps to 0; any other address (including out-of-range ones) just increments.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(DEPTH - 1))
            return '0;
        return a + ADDR_W'(1);
    endfunction

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        cnt_next        = cnt_reg;
        rd_pending_next = 1'b0;
        s_waitrequest   = 1'b0;
        ram_address     = s_address;
        cs_raw          = 1'b0;
        wr_raw          = 1'b0;
        beats           = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;

        case (state_reg)
            IDLE: begin
                // A simultaneous read and write is illegal; the read takes priority.
                if (s_read) begin
                    cs_raw          = 1'b1;
                    rd_pending_next = 1'b1;
                    if (beats > BURST_W'(1)) begin
                        addr_next  = next_addr(s_address);
                        cnt_next   = beats - BURST_W'(1);
                        state_next = RD_BURST;
                    end
                end else if (s_write) begin
                    cs_raw = 1'b1;
                    wr_raw = 1'b1;
                    if (beats > BURST_W'(1)) begin
                        addr_next  = next_addr(s_address);
                        cnt_next   = beats - BURST_W'(1);
                        state_next = WR_BURST;
                    end
                end
            end
            WR_BURST: begin
                ram_address = addr_reg;
                if (s_write) begin
                    cs_raw    = 1'b1;
                    wr_raw    = 1'b1;
                    addr_next = next_addr(addr_reg);
                    cnt_next  = cnt_reg - BURST_W'(1);
                    if (cnt_reg == BURST_W'(1))
                        state_next = IDLE;
                end
            end
            RD_BURST: begin
                s_waitrequest   = 1'b1;
                ram_address     = addr_reg;
                cs_raw          = 1'b1;
                rd_pending_next = 1'b1;
                addr_next       = next_addr(addr_reg);
                cnt_next        = cnt_reg - BURST_W'(1);
                if (cnt_reg == BURST_W'(1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef ONCHIP_RAM_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    logic rd_oob_reg, err_sticky_reg;

    assign beat_ok = ({1'b0, ram_address} < DEPTH_EXT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_oob_reg     <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else begin
            rd_oob_reg     <= rd_pending_next & ~beat_ok;
            err_sticky_reg <= err_sticky_reg | (cs_raw & ~beat_ok);
        end
    end

    assign s_readdata = (rd_pending_reg && !rd_oob_reg) ? ram_readdata : '0;
    assign s_response = (rd_pending_reg && rd_oob_reg) ? 2'b10 : 2'b00;
    assign err_sticky = err_sticky_reg;
`else
    assign beat_ok    = 1'b1;
    assign s_readdata = rd_pending_reg ? ram_readdata : '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            cnt_reg        <= '0;
            rd_pending_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            cnt_reg        <= cnt_next;
            rd_pending_reg <= rd_pending_next;
        end
    end

    // Chipselect is forced low while reset is held so no stray access reaches the RAM.
    assign ram_chipselect  = cs_raw & beat_ok & reset_n;
    assign ram_write       = wr_raw & beat_ok & reset_n;
    assign ram_byteenable  = s_byteenable;
    assign ram_writedata   = s_writedata;
    assign ram_clken       = 1'b1;
    assign s_readdatavalid = rd_pending_reg;

endmodule

// File: tb/tb_onchip_ram_burst_adapter.sv
// Directed bench for onchip_ram_burst_adapter: single-beat vector table plus burst, wrap and reset sequences.
module tb_onchip_ram_burst_adapter;
    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 5120;
    localparam int BURST_W = 4;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [ADDR_W-1:0]   s_address = '0;
    logic [BURST_W-1:0]  s_burstcount = '0;
    logic [3:0]          s_byteenable = '0;
    logic                s_read = 1'b0;
    logic                s_write = 1'b0;
    logic [DATA_W-1:0]   s_writedata = '0;
    logic                s_waitrequest;
    logic [DATA_W-1:0]   s_readdata;
    logic                s_readdatavalid;
    logic [ADDR_W-1:0]   ram_address;
    logic [3:0]          ram_byteenable;
    logic                ram_chipselect;
    logic                ram_write;
    logic [DATA_W-1:0]   ram_writedata;
    logic                ram_clken;
    logic [DATA_W-1:0]   ram_readdata;
`ifdef ONCHIP_RAM_RANGE_CHECK_EN
    logic [1:0]          s_response;
    logic                err_sticky;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onchip_ram_burst_adapter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BURST_W(BURST_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .s_address(s_address),
        .s_burstcount(s_burstcount),
        .s_byteenable(s_byteenable),
        .s_read(s_read),
        .s_write(s_write),
        .s_writedata(s_writedata),
        .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .ram_address(ram_address),
        .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect),
        .ram_write(ram_write),
        .ram_writedata(ram_writedata),
        .ram_clken(ram_clken),
`ifdef ONCHIP_RAM_RANGE_CHECK_EN
        .s_response(s_response),
        .err_sticky(err_sticky),
`endif
        .ram_readdata(ram_readdata)
    );

    // RAM model: registered address, unregistered q, zero-initialised.
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [ADDR_W-1:0] ram_addr_q = '0;
    always @(posedge clk) begin
        if (ram_chipselect && ram_clken) begin
            if (ram_write)
                for (int i = 0; i < 4; i++)
                    if (ram_byteenable[i]) mem[ram_address][8*i +: 8] = ram_writedata[8*i +: 8];
            ram_addr_q <= ram_address;
        end
    end
    assign ram_readdata = mem[ram_addr_q];

    typedef struct {
        logic [ADDR_W-1:0]  addr;
        logic [BURST_W-1:0] bc;
        logic [3:0]         be;
        logic [31:0]        data;
        logic [31:0]        exp;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [BURST_W-1:0] bc, input logic [3:0] be, input logic [31:0] d);
        s_read       = rd;
        s_write      = wr;
        s_address    = a;
        s_burstcount = bc;
        s_byteenable = be;
        s_writedata  = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 4'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;

        vecs[0] = '{13'h010,  4'd1, 4'hF,    32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{13'h011,  4'd1, 4'hF,    32'h12345678, 32'h12345678};
        vecs[2] = '{13'h011,  4'd1, 4'b0101, 32'hAABBCCDD, 32'h12BB56DD};
        vecs[3] = '{13'h011,  4'd0, 4'b1000, 32'hFFFFFFFF, 32'hFFBB56DD};
        vecs[4] = '{13'h13FF, 4'd1, 4'hF,    32'hCAFEF00D, 32'hCAFEF00D};
        vecs[5] = '{13'h000,  4'd0, 4'hF,    32'h0BADC0DE, 32'h0BADC0DE};

        // Reset state
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_bit("rst_waitrequest", s_waitrequest, 1'b0);
        check_bit("rst_readdatavalid", s_readdatavalid, 1'b0);
        check("rst_readdata", s_readdata, 32'h0);
        check_bit("rst_chipselect", ram_chipselect, 1'b0);
        check_bit("rst_clken", ram_clken, 1'b1);
`ifdef ONCHIP_RAM_RANGE_CHECK_EN
        check_bit("rst_err_sticky", err_sticky, 1'b0);
`endif
        next_cycle();
        reset_n = 1'b1;

        // Single-beat write then read, one table entry per transaction
        for (int v = 0; v < 6; v++) begin
            next_cycle();
            drive(1'b0, 1'b1, vecs[v].addr, vecs[v].bc, vecs[v].be, vecs[v].data);
            settle();
            check_bit("wr_waitrequest", s_waitrequest, 1'b0);
            check_bit("wr_chipselect", ram_chipselect, 1'b1);
            check_bit("wr_ram_write", ram_write, 1'b1);
            check("wr_ram_address", 32'(ram_address), 32'(vecs[v].addr));
            next_cycle();
            drive(1'b1, 1'b0, vecs[v].addr, vecs[v].bc, 4'h0, 32'h0);
            settle();
            check_bit("rd_waitrequest", s_waitrequest, 1'b0);
            check_bit("rd_ram_write", ram_write, 1'b0);
            check_bit("rd_early_valid", s_readdatavalid, 1'b0);
            next_cycle();
            idle();
            settle();
            check_bit("rd_valid", s_readdatavalid, 1'b1);
            check("rd_data", s_readdata, vecs[v].exp);
`ifdef ONCHIP_RAM_RANGE_CHECK_EN
            check("rd_response", 32'(s_response), 32'h0);
`endif
            next_cycle();
            settle();
            check_bit("rd_valid_drop", s_readdatavalid, 1'b0);
            $display("txn %0d: single addr=0x%03h be=%b data=0x%08h", v, vecs[v].addr, vecs[v].be, vecs[v].data);
        end

        // Write burst of 4 at 0x100 with a 2-cycle stall after beat 2, then a back-to-back burst at 0x104
        next_cycle();
        drive(1'b0, 1'b1, 13'h100, 4'd4, 4'hF, 32'd1);
        settle();
        check("wb_addr1", 32'(ram_address), 32'h100);
        next_cycle();
        drive(1'b0, 1'b1, 13'h000, 4'd0, 4'hF, 32'd2);
        settle();
        check("wb_addr2", 32'(ram_address), 32'h101);
        check_bit("wb_wait2", s_waitrequest, 1'b0);
        for (int s = 0; s < 2; s++) begin
            next_cycle();
            idle();
            settle();
            check_bit("wb_stall_cs", ram_chipselect, 1'b0);
        end
        next_cycle();
        drive(1'b0, 1'b1, 13'h000, 4'd0, 4'hF, 32'd3);
        settle();
        check("wb_addr3", 32'(ram_address), 32'h102);
        check_bit("wb_cs3", ram_chipselect, 1'b1);
        next_cycle();
        drive(1'b0, 1'b1, 13'h000, 4'd0, 4'hF, 32'd4);
        settle();
        check("wb_addr4", 32'(ram_address), 32'h103);
        for (int k = 5; k <= 8; k++) begin
            next_cycle();
            drive(1'b0, 1'b1, (k == 5) ? 13'h104 : 13'h000, (k == 5) ? 4'd4 : 4'd0, 4'hF, 32'(k));
            settle();
            check("wb2_addr", 32'(ram_address), 32'h100 + 32'(k - 1));
            check_bit("wb2_cs", ram_chipselect, 1'b1);
        end
        next_cycle();
        idle();
        settle();
        for (int k = 0; k < 8; k++) check("wb_mem", mem[13'h100 + 13'(k)], 32'(k + 1));
        $display("txn: write bursts 0x100 x4 (stalled) and 0x104 x4");

        // Read burst of 8 from 0x100, second read accepted as the 8th beat returns
        next_cycle();
        drive(1'b1, 1'b0, 13'h100, 4'd8, 4'h0, 32'h0);
        settle();
        check_bit("rb_accept_wait", s_waitrequest, 1'b0);
        check_bit("rb_accept_valid", s_readdatavalid, 1'b0);
        check("rb_accept_addr", 32'(ram_address), 32'h100);
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            idle();
            settle();
            check_bit("rb_wait", s_waitrequest, 1'b1);
            check_bit("rb_valid", s_readdatavalid, 1'b1);
            check("rb_data", s_readdata, 32'(k));
            check("rb_addr", 32'(ram_address), 32'h100 + 32'(k));
        end
        next_cycle();
        drive(1'b1, 1'b0, 13'h010, 4'd1, 4'h0, 32'h0);
        settle();
        check_bit("rb_b2b_wait", s_waitrequest, 1'b0);
        check_bit("rb_last_valid", s_readdatavalid, 1'b1);
        check("rb_last_data", s_readdata, 32'd8);
        check("rb_b2b_addr", 32'(ram_address), 32'h010);
        next_cycle();
        idle();
        settle();
        check_bit("rb_b2b_valid", s_readdatavalid, 1'b1);
        check("rb_b2b_data", s_readdata, 32'hDEADBEEF);
        next_cycle();
        settle();
        check_bit("rb_end_valid", s_readdatavalid, 1'b0);
        $display("txn: read burst 0x100 x8 + back-to-back read 0x010");

        // Wrap at the top of the RAM: write 3 at 5118 then read them back
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive(1'b0, 1'b1, (k == 0) ? 13'd5118 : 13'd0, (k == 0) ? 4'd3 : 4'd0, 4'hF, 32'hA0000000 + 32'(k));
            settle();
            check("wrap_wr_addr", 32'(ram_address), (k == 2) ? 32'd0 : 32'd5118 + 32'(k));
        end
        next_cycle();
        drive(1'b1, 1'b0, 13'd5118, 4'd3, 4'h0, 32'h0);
        settle();
        check("wrap_rd_addr0", 32'(ram_address), 32'd5118);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            idle();
            settle();
            check_bit("wrap_rd_valid", s_readdatavalid, 1'b1);
            check("wrap_rd_data", s_readdata, 32'hA0000000 + 32'(k));
            check_bit("wrap_rd_wait", s_waitrequest, (k < 2) ? 1'b1 : 1'b0);
        end
        next_cycle();
        settle();
        check_bit("wrap_end_valid", s_readdatavalid, 1'b0);
        $display("txn: wrap burst at 5118 x3 write/read");

        // Asynchronous reset during beat 3 of an 8-beat read
        next_cycle();
        drive(1'b1, 1'b0, 13'h100, 4'd8, 4'h0, 32'h0);
        next_cycle();
        idle();
        next_cycle();
        #1;
        check_bit("arst_pre_valid", s_readdatavalid, 1'b1);
        reset_n = 1'b0;
        #1;
        check_bit("arst_valid", s_readdatavalid, 1'b0);
        check_bit("arst_cs", ram_chipselect, 1'b0);
        check("arst_data", s_readdata, 32'h0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        settle();
        check_bit("arst_rel_wait", s_waitrequest, 1'b0);
        check_bit("arst_rel_valid", s_readdatavalid, 1'b0);
        next_cycle();
        drive(1'b1, 1'b0, 13'h103, 4'd1, 4'h0, 32'h0);
        settle();
        check_bit("arst_new_wait", s_waitrequest, 1'b0);
        next_cycle();
        idle();
        settle();
        check("arst_new_data", s_readdata, 32'd4);
        $display("txn: reset during 8-beat read, then read 0x103");

`ifdef ONCHIP_RAM_RANGE_CHECK_EN
        // Out-of-range read
        next_cycle();
        drive(1'b1, 1'b0, 13'd5125, 4'd1, 4'h0, 32'h0);
        settle();
        check_bit("oob_cs", ram_chipselect, 1'b0);
        check_bit("oob_sticky_early", err_sticky, 1'b0);
        next_cycle();
        idle();
        settle();
        check_bit("oob_valid", s_readdatavalid, 1'b1);
        check("oob_data", s_readdata, 32'h0);
        check("oob_response", 32'(s_response), 32'h2);
        check_bit("oob_sticky", err_sticky, 1'b1);
        $display("txn: out-of-range read at 5125");
`endif

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
